// File: rtl/instr_sequencer.sv
// Instruction feeder for the 9-bit mv/mvi/add/sub processor: drives DIN/Run from a small program
// store and paces on Done. Define INSTR_SEQ_STEP_EN to add single-step (Step input, PAUSE state).
module instr_sequencer #(
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
`ifdef INSTR_SEQ_STEP_EN
    input  logic          Step,
`endif
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [8:0]    prog_data,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Halted,
    output logic          Error
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned CntW  = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  OpMvi  = 3'b001;
    localparam logic [2:0]  OpHalt = 3'b111;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StPause} state_e;

    state_e          state_q;
    logic [8:0]      mem [Depth];
    logic [CntW-1:0] cnt_q;
    logic            is_mvi_q;
    logic [8:0]      cur_word;
    logic [AW-1:0]   pc_plus1;
    logic [AW:0]     pc_adv;

    assign cur_word = mem[PC];
    assign pc_plus1 = PC + AW'(1);
    // Extra top bit flags a wrap past the last store address.
    assign pc_adv   = {1'b0, PC} + (is_mvi_q ? (AW+1)'(2) : (AW+1)'(1));
    assign Busy     = (state_q != StIdle);

    always_ff @(posedge Clock) begin
        if (prog_we && !Busy) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= StIdle;
            PC       <= '0;
            DIN      <= '0;
            Run      <= 1'b0;
            Halted   <= 1'b0;
            Error    <= 1'b0;
            cnt_q    <= '0;
            is_mvi_q <= 1'b0;
        end else begin
            Run <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        PC      <= '0;
                        Halted  <= 1'b0;
                        Error   <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (cur_word[8:6] == OpHalt) begin
                        Halted  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        DIN      <= cur_word;
                        Run      <= 1'b1;
                        cnt_q    <= '0;
                        is_mvi_q <= (cur_word[8:6] == OpMvi);
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (is_mvi_q) begin
                        DIN <= mem[pc_plus1];
                    end
                    if (Done) begin
                        PC <= pc_adv[AW-1:0];
                        if (pc_adv[AW]) begin
                            Halted  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
`ifdef INSTR_SEQ_STEP_EN
                            state_q <= StPause;
`else
                            state_q <= StIssue;
`endif
                        end
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        Error   <= 1'b1;
                        Halted  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
`ifdef INSTR_SEQ_STEP_EN
                StPause: begin
                    if (Step) begin
                        state_q <= StIssue;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
